// File: rtl/rtc_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_pkg
//  Purpose  : Shared types and constants for the RTC bus cycle generator:
//             FSM state encoding, idle levels of the RTC control pins and
//             the default bus phase length.
//  Revision : 1.0 - initial release
// ============================================================================
package rtc_bus_pkg;

  // Default number of clk cycles per bus phase (legal range 1..256)
  localparam int DEFAULT_PHASE_CYCLES = 4;

  // Inactive levels of the active-low RTC control pins
  localparam logic CS_IDLE     = 1'b1;
  localparam logic STROBE_IDLE = 1'b1;

  // Bus cycle state encoding
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_SETUP = 3'd1,
    ST_ADDR_HOLD  = 3'd2,
    ST_STROBE     = 3'd3,
    ST_DATA_HOLD  = 3'd4,
    ST_RECOVER    = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rtc_bus_cycle_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_cycle_gen_if
//  Purpose  : Bundles the controller request/response handshake and the
//             external RTC multiplexed address/data pin group.
//  Ports    : master - controller side (drives requests, pad input value)
//             slave  - bus cycle generator side (drives pins and response)
//  Revision : 1.0 - initial release
// ============================================================================
interface rtc_bus_cycle_gen_if;

  // Controller handshake
  logic       start_write;
  logic       start_read;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       done;
  logic [7:0] rdata;
  logic       busy;

  // RTC pin group (towards the tristate pad logic)
  logic       rtc_cs_n;
  logic       rtc_ale;
  logic       rtc_wr_n;
  logic       rtc_rd_n;
  logic [7:0] rtc_ad_out;
  logic       rtc_ad_oe;
  logic [7:0] rtc_ad_in;

  modport master (
    output start_write, start_read, addr, wdata, rtc_ad_in,
    input  done, rdata, busy,
    input  rtc_cs_n, rtc_ale, rtc_wr_n, rtc_rd_n, rtc_ad_out, rtc_ad_oe
  );

  modport slave (
    input  start_write, start_read, addr, wdata, rtc_ad_in,
    output done, rdata, busy,
    output rtc_cs_n, rtc_ale, rtc_wr_n, rtc_rd_n, rtc_ad_out, rtc_ad_oe
  );

endinterface
`default_nettype wire

// File: rtl/rtc_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_phase_timer
//  Purpose  : Loadable 8-bit down-counter timing one bus phase. Counts down
//             while enabled and parks at zero; load has priority over count.
//  Ports    : clk, reset     - clock, synchronous active-high reset
//             load, load_val - reload strobe and reload value
//             en             - decrement enable
//             zero           - counter currently at zero
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_phase_timer (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       load,
  input  wire logic       en,
  input  wire logic [7:0] load_val,
  output logic            zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign zero = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/rtc_bus_cycle_gen.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_cycle_gen
//  Purpose  : Runs one multiplexed address/data bus cycle on the external RTC
//             pins per controller request, with PHASE_CYCLES clocks per
//             phase, and returns a completion level plus the read byte.
//  Ports    : clk, reset - clock, synchronous active-high reset
//             bus        - slave modport: start_write/start_read/addr/wdata
//                          in, done/rdata/busy out, RTC pins out, rtc_ad_in in
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_cycle_gen
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYCLES = DEFAULT_PHASE_CYCLES
) (
  input  wire logic          clk,
  input  wire logic          reset,
  rtc_bus_cycle_gen_if.slave bus
);

  localparam logic [7:0] c_RELOAD = 8'(PHASE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic       r_dir_wr, w_dir_wr_nxt;
  logic [7:0] r_addr,   w_addr_nxt;
  logic [7:0] r_wdata,  w_wdata_nxt;
  logic       r_blk_rd, w_blk_rd_nxt;
  logic [7:0] r_rdata,  w_rdata_nxt;

  logic       r_done,   w_done_nxt;
  logic       r_busy,   w_busy_nxt;
  logic       r_cs_n,   w_cs_n_nxt;
  logic       r_ale,    w_ale_nxt;
  logic       r_wr_n,   w_wr_n_nxt;
  logic       r_rd_n,   w_rd_n_nxt;
  logic [7:0] r_ad_out, w_ad_out_nxt;
  logic       r_ad_oe,  w_ad_oe_nxt;

  logic       w_load, w_en, w_zero;
  logic       w_orig_start;
  logic       w_rd_req;

  rtc_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .en       (w_en),
    .load_val (c_RELOAD),
    .zero     (w_zero)
  );

  // The request that launched the current cycle; done follows it.
  assign w_orig_start = r_dir_wr ? bus.start_write : bus.start_read;
  // A read that lost arbitration to a write stays masked until it drops.
  assign w_rd_req     = bus.start_read & ~r_blk_rd;

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_en         = 1'b0;
    w_dir_wr_nxt = r_dir_wr;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_blk_rd_nxt = r_blk_rd & bus.start_read;
    w_rdata_nxt  = r_rdata;

    case (r_state)
      ST_IDLE: begin
        if (bus.start_write || w_rd_req) begin
          w_state_nxt  = ST_ADDR_SETUP;
          w_load       = 1'b1;
          w_dir_wr_nxt = bus.start_write;
          w_addr_nxt   = bus.addr;
          w_wdata_nxt  = bus.wdata;
          w_blk_rd_nxt = bus.start_write & bus.start_read;
        end
      end
      ST_ADDR_SETUP: begin
        w_en = 1'b1;
        if (w_zero) begin
          w_state_nxt = ST_ADDR_HOLD;
          w_load      = 1'b1;
        end
      end
      ST_ADDR_HOLD: begin
        w_en = 1'b1;
        if (w_zero) begin
          w_state_nxt = ST_STROBE;
          w_load      = 1'b1;
        end
      end
      ST_STROBE: begin
        w_en = 1'b1;
        if (w_zero) begin
          w_state_nxt = ST_DATA_HOLD;
          w_load      = 1'b1;
          // Last cycle with rd_n low: the RTC is still driving the bus.
          if (!r_dir_wr) begin
            w_rdata_nxt = bus.rtc_ad_in;
          end
        end
      end
      ST_DATA_HOLD: begin
        w_en = 1'b1;
        if (w_zero) begin
          w_state_nxt = ST_RECOVER;
          w_load      = 1'b1;
        end
      end
      ST_RECOVER: begin
        w_en = 1'b1;
        if (w_zero) begin
          // A request withdrawn mid-cycle never sees done.
          w_state_nxt = w_orig_start ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!w_orig_start) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Pin levels are decoded from the state being entered so every pin is
    // registered and changes on the entry edge.
    w_done_nxt   = 1'b0;
    w_busy_nxt   = 1'b1;
    w_cs_n_nxt   = CS_IDLE;
    w_ale_nxt    = 1'b0;
    w_wr_n_nxt   = STROBE_IDLE;
    w_rd_n_nxt   = STROBE_IDLE;
    w_ad_out_nxt = 8'h00;
    w_ad_oe_nxt  = 1'b0;

    case (w_state_nxt)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      ST_ADDR_SETUP: begin
        w_cs_n_nxt   = 1'b0;
        w_ale_nxt    = 1'b1;
        w_ad_oe_nxt  = 1'b1;
        w_ad_out_nxt = w_addr_nxt;
      end
      ST_ADDR_HOLD: begin
        w_cs_n_nxt   = 1'b0;
        w_ad_oe_nxt  = 1'b1;
        w_ad_out_nxt = w_addr_nxt;
      end
      ST_STROBE: begin
        w_cs_n_nxt = 1'b0;
        if (w_dir_wr_nxt) begin
          w_ad_oe_nxt  = 1'b1;
          w_ad_out_nxt = w_wdata_nxt;
          w_wr_n_nxt   = 1'b0;
        end else begin
          w_rd_n_nxt   = 1'b0;
        end
      end
      ST_DATA_HOLD: begin
        w_cs_n_nxt = 1'b0;
        if (w_dir_wr_nxt) begin
          w_ad_oe_nxt  = 1'b1;
          w_ad_out_nxt = w_wdata_nxt;
        end
      end
      ST_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_dir_wr <= 1'b0;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
      r_blk_rd <= 1'b0;
      r_rdata  <= 8'h00;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_cs_n   <= CS_IDLE;
      r_ale    <= 1'b0;
      r_wr_n   <= STROBE_IDLE;
      r_rd_n   <= STROBE_IDLE;
      r_ad_out <= 8'h00;
      r_ad_oe  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir_wr <= w_dir_wr_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_blk_rd <= w_blk_rd_nxt;
      r_rdata  <= w_rdata_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_cs_n   <= w_cs_n_nxt;
      r_ale    <= w_ale_nxt;
      r_wr_n   <= w_wr_n_nxt;
      r_rd_n   <= w_rd_n_nxt;
      r_ad_out <= w_ad_out_nxt;
      r_ad_oe  <= w_ad_oe_nxt;
    end
  end

  assign bus.done       = r_done;
  assign bus.busy       = r_busy;
  assign bus.rdata      = r_rdata;
  assign bus.rtc_cs_n   = r_cs_n;
  assign bus.rtc_ale    = r_ale;
  assign bus.rtc_wr_n   = r_wr_n;
  assign bus.rtc_rd_n   = r_rd_n;
  assign bus.rtc_ad_out = r_ad_out;
  assign bus.rtc_ad_oe  = r_ad_oe;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_cycle_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_bus_cycle_gen
//  Purpose  : Self-checking bench for rtc_bus_cycle_gen. One instance runs
//             with 4-cycle phases, a second with 1-cycle phases. Expected
//             per-cycle pin vectors are queued when a request is issued and
//             popped one per clock as the DUT runs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_cycle_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pad_val;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  rtc_bus_cycle_gen_if bif4 ();
  rtc_bus_cycle_gen_if bif1 ();

  // Pad model: the RTC drives the bus only while rd_n is low.
  assign bif4.rtc_ad_in = bif4.rtc_rd_n ? 8'hFF : pad_val;
  assign bif1.rtc_ad_in = 8'hFF;

  rtc_bus_cycle_gen #(.PHASE_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(bif4));
  rtc_bus_cycle_gen #(.PHASE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bif1));

  typedef struct packed {
    logic       cs_n;
    logic       ale;
    logic       wr_n;
    logic       rd_n;
    logic       ad_oe;
    logic [7:0] ad_out;
    logic       busy;
    logic       done;
  } pins_t;

  pins_t exp_q[$];

  function automatic pins_t idle_pins();
    pins_t p;
    p.cs_n = 1'b1; p.ale = 1'b0; p.wr_n = 1'b1; p.rd_n = 1'b1;
    p.ad_oe = 1'b0; p.ad_out = 8'h00; p.busy = 1'b0; p.done = 1'b0;
    return p;
  endfunction

  // k: 0 addr setup, 1 addr hold, 2 strobe, 3 data hold, 4 recover, 5 done
  function automatic pins_t phase_pins(int k, bit wr, logic [7:0] a, logic [7:0] d);
    pins_t p = idle_pins();
    p.busy = 1'b1;
    case (k)
      0: begin p.cs_n = 1'b0; p.ale = 1'b1; p.ad_oe = 1'b1; p.ad_out = a; end
      1: begin p.cs_n = 1'b0; p.ad_oe = 1'b1; p.ad_out = a; end
      2: begin
        p.cs_n = 1'b0;
        if (wr) begin p.ad_oe = 1'b1; p.ad_out = d; p.wr_n = 1'b0; end
        else    p.rd_n = 1'b0;
      end
      3: begin
        p.cs_n = 1'b0;
        if (wr) begin p.ad_oe = 1'b1; p.ad_out = d; end
      end
      5: p.done = 1'b1;
      default: ;
    endcase
    return p;
  endfunction

  task automatic push_cycle(int phase_len, bit wr, logic [7:0] a, logic [7:0] d, bit with_done);
    for (int k = 0; k < 5; k++)
      repeat (phase_len) exp_q.push_back(phase_pins(k, wr, a, d));
    if (with_done) exp_q.push_back(phase_pins(5, wr, a, d));
  endtask

  function automatic pins_t pins4();
    return {bif4.rtc_cs_n, bif4.rtc_ale, bif4.rtc_wr_n, bif4.rtc_rd_n,
            bif4.rtc_ad_oe, bif4.rtc_ad_out, bif4.busy, bif4.done};
  endfunction

  function automatic pins_t pins1();
    return {bif1.rtc_cs_n, bif1.rtc_ale, bif1.rtc_wr_n, bif1.rtc_rd_n,
            bif1.rtc_ad_oe, bif1.rtc_ad_out, bif1.busy, bif1.done};
  endfunction

  // Bus contention guard, checked every cycle on both instances.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if ((bif4.rtc_ad_oe && !bif4.rtc_rd_n) || (bif1.rtc_ad_oe && !bif1.rtc_rd_n)) begin
        errors++;
        $display("FAIL contention: ad_oe=%b/%b rd_n=%b/%b, required never both active",
                 bif4.rtc_ad_oe, bif1.rtc_ad_oe, bif4.rtc_rd_n, bif1.rtc_rd_n);
      end
    end
  end

  task automatic test_reset();
    pins_t got;
    reset = 1'b1;
    pad_val = 8'h00;
    bif4.start_write = 1'b0; bif4.start_read = 1'b0; bif4.addr = 8'h00; bif4.wdata = 8'h00;
    bif1.start_write = 1'b0; bif1.start_read = 1'b0; bif1.addr = 8'h00; bif1.wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    got = pins4(); checks++;
    if (got !== idle_pins() || bif4.rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset4: pins=%h rdata=%h, required pins=%h rdata=00", got, bif4.rdata, idle_pins());
    end
    got = pins1(); checks++;
    if (got !== idle_pins() || bif1.rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset1: pins=%h rdata=%h, required pins=%h rdata=00", got, bif1.rdata, idle_pins());
    end
  endtask

  task automatic test_write();
    pins_t got, e;
    @(posedge clk); #1;
    bif4.addr = 8'h21; bif4.wdata = 8'h45; bif4.start_write = 1'b1;
    push_cycle(4, 1'b1, 8'h21, 8'h45, 1'b1);
    exp_q.push_back(idle_pins());
    @(posedge clk);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      got = pins4(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL write cyc%0d: pins=%h, required %h", i, got, e);
      end
      if (i == 20) bif4.start_write = 1'b0;
    end
  endtask

  task automatic test_read();
    pins_t got, e;
    pad_val = 8'hA7;
    @(posedge clk); #1;
    bif4.addr = 8'h41; bif4.wdata = 8'h99; bif4.start_read = 1'b1;
    push_cycle(4, 1'b0, 8'h41, 8'h99, 1'b1);
    exp_q.push_back(idle_pins());
    @(posedge clk);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      got = pins4(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL read cyc%0d: pins=%h, required %h", i, got, e);
      end
      if (i == 20) begin
        checks++;
        if (bif4.rdata !== 8'hA7) begin
          errors++;
          $display("FAIL read rdata: got %h, required a7", bif4.rdata);
        end
        bif4.start_read = 1'b0;
      end
    end
  endtask

  task automatic test_write_after_read();
    pins_t got, e;
    pad_val = 8'h11;
    @(posedge clk); #1;
    bif4.addr = 8'h10; bif4.wdata = 8'h5A; bif4.start_write = 1'b1;
    push_cycle(4, 1'b1, 8'h10, 8'h5A, 1'b1);
    exp_q.push_back(idle_pins());
    @(posedge clk);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      got = pins4(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wr_after_rd cyc%0d: pins=%h, required %h", i, got, e);
      end
      if (i == 20) bif4.start_write = 1'b0;
    end
    checks++;
    if (bif4.rdata !== 8'hA7) begin
      errors++;
      $display("FAIL rdata_hold: got %h, required a7", bif4.rdata);
    end
  endtask

  task automatic test_both();
    pins_t got, e;
    @(posedge clk); #1;
    bif4.addr = 8'h0A; bif4.wdata = 8'h77;
    bif4.start_write = 1'b1; bif4.start_read = 1'b1;
    push_cycle(4, 1'b1, 8'h0A, 8'h77, 1'b1);
    repeat (4) exp_q.push_back(idle_pins());
    @(posedge clk);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      got = pins4(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL both cyc%0d: pins=%h, required %h", i, got, e);
      end
      if (i == 20) bif4.start_write = 1'b0;  // read stays high: must not retrigger
      if (i == 23) bif4.start_read = 1'b0;
    end
  endtask

  task automatic test_drop();
    pins_t got, e;
    @(posedge clk); #1;
    bif4.addr = 8'h33; bif4.wdata = 8'h66; bif4.start_write = 1'b1;
    push_cycle(4, 1'b1, 8'h33, 8'h66, 1'b0);
    repeat (2) exp_q.push_back(idle_pins());
    @(posedge clk);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      got = pins4(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL drop cyc%0d: pins=%h, required %h", i, got, e);
      end
      if (i == 9) bif4.start_write = 1'b0;  // second cycle of STROBE
    end
  endtask

  task automatic test_reset_mid();
    pins_t got, e;
    pad_val = 8'h3C;
    @(posedge clk); #1;
    bif4.addr = 8'h41; bif4.start_read = 1'b1;
    push_cycle(4, 1'b0, 8'h41, 8'h00, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      got = pins4(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rst_mid cyc%0d: pins=%h, required %h", i, got, e);
      end
    end
    exp_q.delete();
    reset = 1'b1;
    bif4.start_read = 1'b0;
    @(negedge clk);
    got = pins4(); checks++;
    if (got !== idle_pins() || bif4.rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid after: pins=%h rdata=%h, required pins=%h rdata=00",
               got, bif4.rdata, idle_pins());
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_phase1();
    pins_t got, e;
    @(posedge clk); #1;
    bif1.addr = 8'h21; bif1.wdata = 8'h45; bif1.start_write = 1'b1;
    push_cycle(1, 1'b1, 8'h21, 8'h45, 1'b1);
    exp_q.push_back(idle_pins());
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      got = pins1(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL phase1 cyc%0d: pins=%h, required %h", i, got, e);
      end
      if (i == 5) bif1.start_write = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_write_after_read();
    test_both();
    test_drop();
    test_reset_mid();
    test_phase1();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rtc_bus_cycle_gen.md
Name: rtc_bus_cycle_gen

Overview:
- Downstream stage of the RTC command controller.
- Takes the controller's write/read requests (address, data) and runs one multiplexed address/data bus cycle on the external RTC pins with programmable phase timing.
- Returns a completion level and the read byte to the controller.
- Sits between the controller and the top-level tristate pad logic.

Parameters:
- PHASE_CYCLES, 4, clk cycles per bus phase; legal range 1..256.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_write  in  1  write request level from controller; held until done is seen
- start_read  in  1  read request level from controller; held until done is seen
- addr  in  8  RTC register address
- wdata  in  8  write data
- done  out  1  level: transaction complete; held while the originating start stays high
- rdata  out  8  last byte read; held until the next read completes
- busy  out  1  high from the capture edge until return to IDLE
- rtc_cs_n  out  1  chip select, active low
- rtc_ale  out  1  address strobe, active high
- rtc_wr_n  out  1  write strobe, active low
- rtc_rd_n  out  1  read strobe, active low
- rtc_ad_out  out  8  value driven on the A/D bus
- rtc_ad_oe  out  1  A/D output enable; pad drives the bus when 1
- rtc_ad_in  in  8  A/D bus value from the pad

Behaviour:
- Reset values: done=0, busy=0, rdata=0x00, rtc_cs_n=1, rtc_ale=0, rtc_wr_n=1, rtc_rd_n=1, rtc_ad_out=0x00, rtc_ad_oe=0, state=IDLE, counter=0.
- Reset mid-transaction: all outputs above return to their reset values on the next edge; no partial strobe remains.
- State machine: IDLE, ADDR_SETUP, ADDR_HOLD, STROBE, DATA_HOLD, RECOVER, DONE.
- All pin outputs are registered and change on the edge that enters a state.
- IDLE:
  - If start_write or start_read is high, capture addr, wdata and direction (write priority when both are high).
  - Load the counter with PHASE_CYCLES-1 and go to ADDR_SETUP. busy=1.
- ADDR_SETUP: cs_n=0, ale=1, ad_oe=1, ad_out=captured addr.
- ADDR_HOLD: ale=0; address still driven.
- STROBE:
  - Write: ad_out=wdata, ad_oe=1, wr_n=0.
  - Read: ad_oe=0, rd_n=0.
  - Read data: rdata <= rtc_ad_in on the edge leaving STROBE (last cycle of rd_n low).
- DATA_HOLD:
  - wr_n=1, rd_n=1, cs_n=0.
  - Write keeps wdata driven with ad_oe=1; read keeps ad_oe=0.
- RECOVER: cs_n=1, ad_oe=0, ad_out=0.
- Each non-IDLE, non-DONE state lasts exactly PHASE_CYCLES cycles:
  - The counter decrements to 0, then the state advances and the counter reloads.
  - Counter is 8 bits; a reload of PHASE_CYCLES-1 with PHASE_CYCLES=1 gives single-cycle phases.
- Latency: done rises 5*PHASE_CYCLES clocks after the capture edge.
- DONE:
  - done=1 while the originating start input stays high.
  - When it drops, done=0, busy=0 and the state returns to IDLE on the next edge.
- Start dropped before completion: the cycle still runs to the end; RECOVER goes directly to IDLE and done is never asserted.
- start_read and start_write both high at capture: write executes; the read request is ignored until both drop and reassert.
- A start held high through DONE→IDLE does not retrigger; a new capture requires the start to be seen low in DONE first.
- rtc_ad_oe and rtc_rd_n are never simultaneously active (bus contention guard); assert this in verification.

Decomposition:
- Package rtc_bus_pkg:
  - state encoding constants (3-bit)
  - idle pin-level constants (CS_IDLE=1, STROBE_IDLE=1)
  - default PHASE_CYCLES
- Sub-module rtc_phase_timer:
  - loadable 8-bit down-counter; inputs load, en; output zero flag.
  - Instantiated once.

Test Plan:
- Write, PHASE_CYCLES=4, addr=0x21, wdata=0x45, start_write held:
  - ale high for 4 cycles with ad_out=0x21, then hold for 4 cycles.
  - wr_n low for exactly 4 cycles with ad_out=0x45, ad_oe=1.
  - done=1 exactly 20 clocks after capture.
  - Dropping start → done=0 and IDLE next edge.
- Read, addr=0x41, pad returns 0xA7 during rd_n low:
  - ad_oe=0 throughout STROBE/DATA_HOLD.
  - rdata=0xA7 when done rises; rdata unchanged after a following write.
- start_write and start_read asserted together, addr=0x0A: wr_n pulses, rd_n never goes low.
- start_write dropped during STROBE: cycle completes (wr_n full 4 cycles), done stays 0, busy falls after RECOVER.
- reset asserted in the second cycle of STROBE (read): next edge rd_n=1, cs_n=1, ad_oe=0, busy=0, rdata=0x00.
- PHASE_CYCLES=1: write completes with done high 5 clocks after capture; each phase is one cycle wide.
